hazard_ctrl: RTL and testbench

Hazard and pipeline-sequencing controller for the 5-stage MIPS pipeline. It generates the IF/ID stall and flush controls and drives the ID/EX register clear, so a bubble is inserted whenever EX must not advance. It also produces the forwarding selects for the EX and ID stages. It tracks a multi-cycle mult/div unit through a busy FSM, which stalls HI/LO consumers until the result is ready.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/md_busy_tracker.sv | 35 +++
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding encodings, mult/div state encoding and defaults for hazard_ctrl
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam int MD_LAT_DEFAULT = 32;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // $0 is hardwired zero, so it never creates a dependency
    function automatic logic regHit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: tracks an accepted mult/div op, busy for exactly MD_LAT cycles after the accept edge
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic busy
);

    md_state_t        state;
    logic [CNT_W-1:0] count;

    // accept only takes effect in idle; the op retires on the cycle the count reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            count <= '0;
        end else if (state == MD_IDLE) begin
            if (accept) begin
                state <= MD_BUSY;
                count <= CNT_W'(MD_LAT - 1);
            end
        end else begin
            state <= (count == '0) ? MD_IDLE : MD_BUSY;
            count <= (count == '0) ? '0 : count - 1'b1;
        end
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline; HAZARD_PERF_EN adds the StallCycles counter
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MdStartD,
    input  logic       MdReadD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic [4:0] WriteRegM,
    input  logic       RegWriteM,
    input  logic       MemtoRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       MdBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCycles
`endif
);

    logic lwStall, brStall, mdStall, stall;

    // EX operand selects: MEM result is newer than WB, so it wins
    always_comb begin
        ForwardAE = (RegWriteM && regHit(RsE, WriteRegM)) ? FWD_MEM :
                    (RegWriteW && regHit(RsE, WriteRegW)) ? FWD_WB  : FWD_NONE;
        ForwardBE = (RegWriteM && regHit(RtE, WriteRegM)) ? FWD_MEM :
                    (RegWriteW && regHit(RtE, WriteRegW)) ? FWD_WB  : FWD_NONE;
    end

    assign ForwardAD = RegWriteM && regHit(RsD, WriteRegM);
    assign ForwardBD = RegWriteM && regHit(RtD, WriteRegM);

    // a branch compared in ID cannot see an ALU result still in EX or a load still in MEM
    always_comb begin
        lwStall = MemtoRegE && (regHit(RsD, WriteRegE) || regHit(RtD, WriteRegE));
        brStall = BranchD && ((RegWriteE && (regHit(RsD, WriteRegE) || regHit(RtD, WriteRegE))) ||
                              (MemtoRegM && (regHit(RsD, WriteRegM) || regHit(RtD, WriteRegM))));
        mdStall = MdBusy && (MdStartD || MdReadD);
        stall   = lwStall || brStall || mdStall;
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    // a stalled branch re-resolves next cycle, so the flush waits for it
    assign FlushD = PCSrcD && !stall;

    md_busy_tracker #(
        .MD_LAT(MD_LAT),
        .CNT_W (CNT_W)
    ) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .accept(MdStartD && !lwStall && !brStall),
        .busy  (MdBusy)
    );

`ifdef HAZARD_PERF_EN
    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCycles <= '0;
        else if (stall && (StallCycles != 32'hFFFF_FFFF))
            StallCycles <= StallCycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, PCSrcD, MdStartD, MdReadD;
    logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles;
`endif

    int checks = 0;
    int errors = 0;

    // model state: cycles of mult/div work left, and stalled cycles seen
    int remaining = 0;
    longint perf = 0;

    // model outputs
    bit expStall, expFlushD, expFAD, expFBD, expBusy, expLw, expBr;
    int expFAE, expFBE;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LAT(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MdStartD(MdStartD), .MdReadD(MdReadD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MdBusy(MdBusy)
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles)
`endif
    );

    function automatic bit same(input int a, input int b);
        return (a != 0) && (a == b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model();
        int fm, fw;
        expLw  = MemtoRegE && (same(WriteRegE, RsD) || same(WriteRegE, RtD));
        expBr  = BranchD && ((RegWriteE && (same(WriteRegE, RsD) || same(WriteRegE, RtD))) ||
                             (MemtoRegM && (same(WriteRegM, RsD) || same(WriteRegM, RtD))));
        expBusy  = remaining > 0;
        expStall = expLw || expBr || (expBusy && (MdStartD || MdReadD));
        expFlushD = PCSrcD && !expStall;
        fm = 2; fw = 1;
        expFAE = (RegWriteM && same(RsE, WriteRegM)) ? fm : (RegWriteW && same(RsE, WriteRegW)) ? fw : 0;
        expFBE = (RegWriteM && same(RtE, WriteRegM)) ? fm : (RegWriteW && same(RtE, WriteRegW)) ? fw : 0;
        expFAD = RegWriteM && same(RsD, WriteRegM);
        expFBD = RegWriteM && same(RtD, WriteRegM);
    endtask

    task automatic checkAll();
        model();
        check("StallF", StallF, expStall);
        check("StallD", StallD, expStall);
        check("FlushE", FlushE, expStall);
        check("FlushD", FlushD, expFlushD);
        check("ForwardAE", ForwardAE, expFAE);
        check("ForwardBE", ForwardBE, expFBE);
        check("ForwardAD", ForwardAD, expFAD);
        check("ForwardBD", ForwardBD, expFBD);
        check("MdBusy", MdBusy, expBusy);
`ifdef HAZARD_PERF_EN
        check("StallCycles", StallCycles, perf[31:0]);
`endif
    endtask

    // inputs are set just after a negedge; check, cross one rising edge, return at the next negedge
    task automatic step();
        #1;
        checkAll();
        @(posedge clk);
        if (expStall && perf < 64'hFFFF_FFFF) perf++;
        if (remaining > 0) remaining--;
        else if (MdStartD && !expLw && !expBr) remaining = LAT;
        @(negedge clk);
    endtask

    task automatic clearInputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {BranchD, PCSrcD, MdStartD, MdReadD} = '0;
        {RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW} = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);
        #1;
        checkAll();
        rst_n = 1'b1;
        @(negedge clk);
        step();

        // load-use
        MemtoRegE = 1; WriteRegE = 2; RsD = 2;
        #1; check("lw_stall", StallF, 1'b1);
        step();
        RsD = 0; WriteRegE = 0;
        #1; check("lw_r0", StallD, 1'b0);
        step();

        // EX forwarding priority
        clearInputs();
        RsE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
        #1; check("fwd_mem", ForwardAE, 2'b10);
        step();
        RegWriteM = 0;
        #1; check("fwd_wb", ForwardAE, 2'b01);
        step();
        RsE = 0;
        #1; check("fwd_r0", ForwardAE, 2'b00);
        step();

        // branch hazard wins over taken branch
        clearInputs();
        BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
        #1; check("br_stall", StallF, 1'b1); check("br_noflush", FlushD, 1'b0);
        step();
        RegWriteE = 0;
        #1; check("br_flushD", FlushD, 1'b1); check("br_flushE", FlushE, 1'b0);
        step();

        // mult/div then mfhi during busy
        clearInputs();
        MdStartD = 1;
        step();
        MdStartD = 0; MdReadD = 1;
        for (int i = 0; i < LAT; i++) begin
            #1; check("md_busy", MdBusy, 1'b1); check("md_rdstall", StallD, 1'b1);
            step();
        end
        #1; check("md_done", MdBusy, 1'b0); check("md_rdgo", StallD, 1'b0);
        step();

        // back-to-back mult/div
        MdReadD = 0; MdStartD = 1;
        step();
        for (int i = 0; i < LAT; i++) begin
            #1; check("b2b_stall", StallD, 1'b1);
            step();
        end
        #1; check("b2b_accept", StallD, 1'b0);
        step();
        MdStartD = 0;
        for (int i = 0; i < LAT; i++) begin
            #1; check("b2b_busy", MdBusy, 1'b1);
            step();
        end
        step();

        // asynchronous reset mid-operation
        MdStartD = 1;
        step();
        MdStartD = 0;
        step();
        #2 rst_n = 1'b0;
        remaining = 0; perf = 0;
        #1; check("rst_busy", MdBusy, 1'b0);
`ifdef HAZARD_PERF_EN
        check("rst_perf", StallCycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        MdReadD = 1;
        #1; check("rst_rd", StallD, 1'b0);
        step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
            RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
            WriteRegE = 5'($urandom_range(0, 7));
            WriteRegM = 5'($urandom_range(0, 7));
            WriteRegW = 5'($urandom_range(0, 7));
            BranchD = ($urandom_range(0, 3) == 0); PCSrcD = $urandom_range(0, 1) == 1;
            MdStartD = ($urandom_range(0, 5) == 0); MdReadD = ($urandom_range(0, 3) == 0);
            RegWriteE = $urandom_range(0, 1) == 1; MemtoRegE = ($urandom_range(0, 3) == 0);
            RegWriteM = $urandom_range(0, 1) == 1; MemtoRegM = ($urandom_range(0, 3) == 0);
            RegWriteW = $urandom_range(0, 1) == 1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
